// File: rtl/vram_arb_pkg.sv
// vram_arbiter shared definitions: owner encoding,
// default geometry and a counter-width helper.
package vram_arb_pkg;

  localparam logic [1:0] OWN_IDLE  = 2'd0;
  localparam logic [1:0] OWN_VIDEO = 2'd1;
  localparam logic [1:0] OWN_HOST  = 2'd2;

  localparam int VRAM_AW = 15;
  localparam int VRAM_DW = 8;

  // Bits needed to hold values 0..limit.
  function automatic int cnt_w(input int limit);
    int w;
    w = 1;
    while ((1 << w) <= limit) w++;
    return w;
  endfunction

endpackage

// File: rtl/vram_arbiter_sat_counter.sv
// sat_counter: synchronous up-counter that sticks at all-ones.
// Ports: clk, rst (sync, high), clr, inc, cnt[W-1:0].
module sat_counter
  import vram_arb_pkg::*;
#(
  parameter int W = 16
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         clr,
  input  logic         inc,
  output logic [W-1:0] cnt
);

  logic at_max;

  assign at_max = &cnt;

  always_ff @(posedge clk) begin
    if (rst || clr) begin
      cnt <= '0;
    end else if (inc && !at_max) begin
      cnt <= cnt + 1'b1;
    end
  end

endmodule

// File: rtl/vram_arbiter.sv
// vram_arbiter: shares a 1-cycle-latency single-port VRAM between
// scanout (strict priority) and a host read/write port.
// Ports: clk, rst (sync, high); vid_req/addr -> vid_data/valid/miss;
// host_valid/we/addr/wdata -> host_ready/rdata/rvalid;
// mem_en/we/addr/wdata, mem_rdata to the RAM; stall_cnt statistics.
// Option: VRAM_ARB_STARVE_GUARD_EN forces a host slot after
// STARVE_LIMIT consecutive denied cycles (video gets vid_miss).
module vram_arbiter
  import vram_arb_pkg::*;
#(
  parameter int AW           = VRAM_AW,
  parameter int DW           = VRAM_DW,
  parameter int STALL_W      = 16,
  parameter int STARVE_LIMIT = 64
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               vid_req,
  input  logic [AW-1:0]      vid_addr,
  output logic [DW-1:0]      vid_data,
  output logic               vid_valid,
  output logic               vid_miss,
  input  logic               host_valid,
  input  logic               host_we,
  input  logic [AW-1:0]      host_addr,
  input  logic [DW-1:0]      host_wdata,
  output logic               host_ready,
  output logic [DW-1:0]      host_rdata,
  output logic               host_rvalid,
  output logic               mem_en,
  output logic               mem_we,
  output logic [AW-1:0]      mem_addr,
  output logic [DW-1:0]      mem_wdata,
  input  logic [DW-1:0]      mem_rdata,
  output logic [STALL_W-1:0] stall_cnt
);

  if (STARVE_LIMIT < 1) begin : g_bad_limit
    $error("vram_arbiter: STARVE_LIMIT must be >= 1");
  end

  logic [1:0]    owner;
  logic          force_host;
  logic          vid_tag;
  logic          host_tag;
  logic [DW-1:0] vid_hold;
  logic [DW-1:0] host_hold;

  // Owner select; a starved host pre-empts video for one cycle.
  always_comb begin
    owner = OWN_IDLE;
    if (rst) begin
      owner = OWN_IDLE;
    end else if (force_host) begin
      owner = OWN_HOST;
    end else if (vid_req) begin
      owner = OWN_VIDEO;
    end else if (host_valid) begin
      owner = OWN_HOST;
    end
  end

  always_comb begin
    mem_en    = 1'b0;
    mem_we    = 1'b0;
    mem_addr  = '0;
    mem_wdata = '0;
    unique case (1'b1)
      owner == OWN_VIDEO: begin
        mem_en   = 1'b1;
        mem_addr = vid_addr;
      end
      owner == OWN_HOST: begin
        mem_en    = 1'b1;
        mem_we    = host_we;
        mem_addr  = host_addr;
        mem_wdata = host_wdata;
      end
      default: ;
    endcase
  end

  assign host_ready = host_valid & (owner == OWN_HOST);

  // Return-path tags: who owns the read data arriving next cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      vid_tag  <= 1'b0;
      host_tag <= 1'b0;
    end else begin
      vid_tag  <= (owner == OWN_VIDEO);
      host_tag <= (owner == OWN_HOST) & ~host_we;
    end
  end

  // Masking with rst drops a read that was in flight at reset.
  assign vid_valid   = vid_tag & ~rst;
  assign host_rvalid = host_tag & ~rst;

  always_ff @(posedge clk) begin
    if (rst) begin
      vid_hold  <= '0;
      host_hold <= '0;
    end else begin
      if (vid_valid) vid_hold <= mem_rdata;
      if (host_rvalid) host_hold <= mem_rdata;
    end
  end

  assign vid_data   = vid_valid ? mem_rdata : vid_hold;
  assign host_rdata = host_rvalid ? mem_rdata : host_hold;

  sat_counter #(
    .W(STALL_W)
  ) u_stall (
    .clk(clk),
    .rst(rst),
    .clr(1'b0),
    .inc(host_valid & ~host_ready),
    .cnt(stall_cnt)
  );

`ifdef VRAM_ARB_STARVE_GUARD_EN
  localparam int SV_W = cnt_w(STARVE_LIMIT);

  logic [SV_W-1:0] starve_cnt;
  logic            miss_tag;

  sat_counter #(
    .W(SV_W)
  ) u_starve (
    .clk(clk),
    .rst(rst),
    .clr(host_ready),
    .inc(host_valid & ~host_ready),
    .cnt(starve_cnt)
  );

  assign force_host =
    host_valid & (starve_cnt >= SV_W'(STARVE_LIMIT));

  always_ff @(posedge clk) begin
    if (rst) begin
      miss_tag <= 1'b0;
    end else begin
      miss_tag <= force_host & vid_req;
    end
  end

  assign vid_miss = miss_tag & ~rst;
`else
  assign force_host = 1'b0;
  assign vid_miss   = 1'b0;
`endif

endmodule
